demux_reg_bank: RTL and testbench
=================================

# demux_reg_bank

Registered 1-to-3 demultiplexer with a readback scanner. It is the write-side counterpart of the 3:1 select path: a 2-bit word on `idata` is steered by `sel` into one of three holding registers on a write strobe. An illegal select is counted and never stored, so no state is implied for the uncovered case. A valid/ready scan port then reads the three registers back out in order. The block sits in the same lab top, fed by the same switch inputs, and drives LEDs and the scan display.

## Interface

Parameters:
- `W`, 2, data width of each register and of `idata`.
- `N`, 3, number of destination registers; legal `sel` values are 0..N-1. Fixed to 3 in this lab.
- `CW`, 4, width of the saturating illegal-write counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `idata`  in  W  write data.
- `sel`  in  2  destination select.
- `we`  in  1  write strobe, sampled each cycle.
- `y0`, `y1`, `y2`  out  W each  holding registers.
- `err`  out  1  sticky flag, set by any write with `sel >= N`.
- `err_cnt`  out  CW  saturating count of illegal writes.
- `err_clr`  in  1  clears `err` and `err_cnt`.
- `scan_start`  in  1  request one readback pass.
- `scan_valid`  out  1  scan beat valid.
- `scan_ready`  in  1  consumer accepts the beat.
- `scan_idx`  out  2  index of the register in the current beat.
- `scan_data`  out  W  snapshot of that register.
- `scan_last`  out  1  high on the beat with `scan_idx == N-1`.
- `scan_busy`  out  1  high while in state SCAN.

## Operation

- Reset values: `y0`..`y2` = 0, `err` = 0, `err_cnt` = 0, `scan_valid` = 0, `scan_idx` = 0, `scan_data` = 0, `scan_last` = 0, `scan_busy` = 0. The FSM resets to IDLE.
- Write: when `we` is high and `sel < N`, `y[sel]` is loaded with `idata`. The other registers hold their values.
- Illegal write: when `we` is high and `sel == 3`, no register changes, `err` is set to 1, and `err_cnt` increments, saturating at 2^CW-1.
- `err_clr` together with an illegal write in the same cycle: the clear is applied first, then the increment, giving `err` = 1 and `err_cnt` = 1.
- `we` low: nothing changes, and `sel` is a don't-care.
- The FSM has two states:
  - IDLE: `scan_valid` = 0. When `scan_start` is high, the FSM moves to SCAN, sets the index to 0 and loads the snapshot of register 0.
  - SCAN: `scan_valid` = 1. A beat transfers on `scan_valid && scan_ready`. A transfer with index < N-1 advances the index and loads the next snapshot. A transfer with index N-1 returns the FSM to IDLE.
- `scan_start` while in SCAN is ignored; it is neither queued nor restarts the pass.
- A snapshot is a registered copy taken when its beat is loaded. If a write to the same register happens on that same edge, the snapshot takes the newly written value (bypass).
- While `scan_valid` is high and `scan_ready` is low, `scan_idx`, `scan_data` and `scan_last` hold stable, even if that register is written. Writes during a scan still update `y*`.
- Asynchronous `rst` in the middle of a scan aborts the pass immediately and all outputs go to their reset values.

## Timing

- Write latency: `y*` and `err`/`err_cnt` reflect a write 1 cycle after the edge on which `we` is sampled.
- Scan: with `scan_start` high at edge k, `scan_valid` is high from cycle k+1 with index 0.
- With `scan_ready` held high, beats go out on consecutive cycles: index 0, 1, 2. `scan_valid` drops in the cycle after the index-2 transfer.
- Minimum spacing between passes is one IDLE cycle. Back-to-back passes are not supported.
- No combinational path exists from any input to any output.

## Structure

- Package `demux_reg_bank_pkg` holds: `W`/`N`/`CW` defaults, the two-state scan FSM enum (IDLE, SCAN), and the constant `LAST_IDX = N-1`.
- The holding registers and the error logic live in the top module.
- Sub-module `bank_scan_fsm` holds the state register, index counter, snapshot register with same-edge bypass, and the `scan_last` generation. It takes the bank contents plus the current write (`we`, `sel`, `idata`) as inputs.

## Test plan

- Reset, then writes of sel=0/`idata`=2'b01, sel=1/2'b10, sel=2/2'b11 on three cycles -> `y0`=01, `y1`=10, `y2`=11, each one cycle after its write, with `err`=0.
- Write with sel=3, `idata`=2'b11 -> `y0`..`y2` unchanged, `err`=1, `err_cnt`=1. Then 20 further illegal writes -> `err_cnt`=15 (saturated). Then `err_clr` together with one illegal write -> `err_cnt`=1.
- Bank = {01,10,11}, `scan_start` pulsed, `scan_ready` held at 1 -> three consecutive beats with (idx,data) = (0,01), (1,10), (2,11), `scan_last` high only on idx 2, `scan_valid` low on the next cycle.
- During a scan, `scan_ready` held at 0 for 3 cycles on beat 1 while `y1` is written to 00 -> `scan_data` stays 10 until accepted, and `y1`=00 afterwards.
- `scan_start` on the same edge as a write of 2'b11 to `y0` -> the beat-0 snapshot is 11. A second `scan_start` mid-pass has no effect.
- `rst` asserted between beats 1 and 2 -> `scan_valid`, `scan_busy` and all registers go to 0 immediately; a subsequent `scan_start` begins again at idx 0.

Source files
------------

// File: rtl/demux_reg_bank_pkg.sv
// rtl/demux_reg_bank_pkg.sv - shared widths, scan FSM states and last-index constant
package demux_reg_bank_pkg;

  localparam int DEF_W    = 2;
  localparam int DEF_N    = 3;
  localparam int DEF_CW   = 4;
  localparam int LAST_IDX = DEF_N - 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/demux_reg_bank_if.sv
// rtl/demux_reg_bank_if.sv - write, error and readback-scan signals of the register bank
interface demux_reg_bank_if
  import demux_reg_bank_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) ();

  logic [W-1:0]  idata;
  logic [1:0]    sel;
  logic          we;
  logic [W-1:0]  y0;
  logic [W-1:0]  y1;
  logic [W-1:0]  y2;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic          err_clr;
  logic          scan_start;
  logic          scan_valid;
  logic          scan_ready;
  logic [1:0]    scan_idx;
  logic [W-1:0]  scan_data;
  logic          scan_last;
  logic          scan_busy;

  modport master (
    output idata, sel, we, err_clr, scan_start, scan_ready,
    input  y0, y1, y2, err, err_cnt, scan_valid, scan_idx, scan_data, scan_last, scan_busy
  );

  modport slave (
    input  idata, sel, we, err_clr, scan_start, scan_ready,
    output y0, y1, y2, err, err_cnt, scan_valid, scan_idx, scan_data, scan_last, scan_busy
  );

endinterface

// File: rtl/bank_scan_fsm.sv
// rtl/bank_scan_fsm.sv - readback scanner: walks the bank once per start with registered beats
module bank_scan_fsm
  import demux_reg_bank_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] bank [N],
  input  logic         we,
  input  logic [1:0]   sel,
  input  logic [W-1:0] idata,
  input  logic         scan_start,
  input  logic         scan_ready,
  output logic         scan_valid,
  output logic [1:0]   scan_idx,
  output logic [W-1:0] scan_data,
  output logic         scan_last,
  output logic         scan_busy
);

  localparam logic [1:0] LAST = 2'(LAST_IDX);

  scan_state_e  state;
  logic [1:0]   next_idx;
  logic [W-1:0] next_snap;

  // A write landing on the same edge as the snapshot load wins over the stale bank value.
  always_comb begin
    next_idx  = (state == IDLE) ? 2'd0 : scan_idx + 2'd1;
    next_snap = '0;
    for (int i = 0; i < N; i++) begin
      if (next_idx == 2'(i)) begin
        next_snap = (we && sel == 2'(i)) ? idata : bank[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      scan_valid <= 1'b0;
      scan_busy  <= 1'b0;
      scan_idx   <= '0;
      scan_data  <= '0;
      scan_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_start) begin
            state      <= SCAN;
            scan_valid <= 1'b1;
            scan_busy  <= 1'b1;
            scan_idx   <= next_idx;
            scan_data  <= next_snap;
            scan_last  <= (next_idx == LAST);
          end
        end
        SCAN: begin
          if (scan_ready) begin
            if (scan_idx == LAST) begin
              state      <= IDLE;
              scan_valid <= 1'b0;
              scan_busy  <= 1'b0;
              scan_idx   <= '0;
              scan_last  <= 1'b0;
            end else begin
              scan_idx   <= next_idx;
              scan_data  <= next_snap;
              scan_last  <= (next_idx == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/demux_reg_bank.sv
// rtl/demux_reg_bank.sv - 1-to-3 registered demux with saturating illegal-write counter and scan port
module demux_reg_bank
  import demux_reg_bank_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input logic             clk,
  input logic             rst,
  demux_reg_bank_if.slave bus
);

  localparam logic [1:0] LAST = 2'(LAST_IDX);

  logic [W-1:0] bank [N];
  logic         illegal;

  assign illegal = bus.we && (bus.sel > LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.we && bus.sel == 2'(i)) bank[i] <= bus.idata;
      end
    end
  end

  // Clear is applied before the increment when both land on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err     <= 1'b0;
      bus.err_cnt <= '0;
    end else if (illegal) begin
      bus.err <= 1'b1;
      if (bus.err_clr)
        bus.err_cnt <= CW'(1);
      else if (bus.err_cnt != {CW{1'b1}})
        bus.err_cnt <= bus.err_cnt + CW'(1);
    end else if (bus.err_clr) begin
      bus.err     <= 1'b0;
      bus.err_cnt <= '0;
    end
  end

  assign bus.y0 = bank[0];
  assign bus.y1 = bank[1];
  assign bus.y2 = bank[2];

  bank_scan_fsm #(
    .W (W),
    .N (N)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .bank       (bank),
    .we         (bus.we),
    .sel        (bus.sel),
    .idata      (bus.idata),
    .scan_start (bus.scan_start),
    .scan_ready (bus.scan_ready),
    .scan_valid (bus.scan_valid),
    .scan_idx   (bus.scan_idx),
    .scan_data  (bus.scan_data),
    .scan_last  (bus.scan_last),
    .scan_busy  (bus.scan_busy)
  );

endmodule

// File: tb/tb_demux_reg_bank.sv
// tb/tb_demux_reg_bank.sv - directed self-checking bench for demux_reg_bank
module tb_demux_reg_bank;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux_reg_bank_if bus ();

  demux_reg_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [1:0] idx,
                          input logic [1:0] data, input logic last);
    chk({tag, "_valid"}, 32'(bus.scan_valid), 32'(v));
    chk({tag, "_busy"},  32'(bus.scan_busy),  32'(v));
    chk({tag, "_idx"},   32'(bus.scan_idx),   32'(idx));
    chk({tag, "_data"},  32'(bus.scan_data),  32'(data));
    chk({tag, "_last"},  32'(bus.scan_last),  32'(last));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.idata = '0; bus.sel = '0; bus.we = 1'b0; bus.err_clr = 1'b0;
    bus.scan_start = 1'b0; bus.scan_ready = 1'b0;
    repeat (2) tick();
    chk("rst_y0", 32'(bus.y0), 0);
    chk("rst_y1", 32'(bus.y1), 0);
    chk("rst_y2", 32'(bus.y2), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_cnt", 32'(bus.err_cnt), 0);
    chk_beat("rst", 1'b0, 2'd0, 2'd0, 1'b0);
    rst = 1'b0;
    tick();

    // legal writes
    bus.we = 1'b1; bus.sel = 2'd0; bus.idata = 2'b01; tick();
    chk("w0_y0", 32'(bus.y0), 1);
    chk("w0_y1", 32'(bus.y1), 0);
    bus.sel = 2'd1; bus.idata = 2'b10; tick();
    chk("w1_y1", 32'(bus.y1), 2);
    chk("w1_y0", 32'(bus.y0), 1);
    bus.sel = 2'd2; bus.idata = 2'b11; tick();
    chk("w2_y2", 32'(bus.y2), 3);
    chk("w2_err", 32'(bus.err), 0);

    // illegal writes and saturation
    bus.sel = 2'd3; bus.idata = 2'b11; tick();
    chk("ill_y0", 32'(bus.y0), 1);
    chk("ill_y1", 32'(bus.y1), 2);
    chk("ill_y2", 32'(bus.y2), 3);
    chk("ill_err", 32'(bus.err), 1);
    chk("ill_cnt", 32'(bus.err_cnt), 1);
    repeat (20) tick();
    chk("sat_cnt", 32'(bus.err_cnt), 15);
    bus.err_clr = 1'b1; tick();
    chk("clrill_cnt", 32'(bus.err_cnt), 1);
    chk("clrill_err", 32'(bus.err), 1);
    bus.we = 1'b0; tick();
    chk("clr_cnt", 32'(bus.err_cnt), 0);
    chk("clr_err", 32'(bus.err), 0);
    bus.err_clr = 1'b0;
    bus.sel = 2'd3; tick();
    chk("nowe_err", 32'(bus.err), 0);

    // full-speed scan
    bus.scan_ready = 1'b1; bus.scan_start = 1'b1; tick();
    bus.scan_start = 1'b0;
    chk_beat("s0", 1'b1, 2'd0, 2'b01, 1'b0);
    tick(); chk_beat("s1", 1'b1, 2'd1, 2'b10, 1'b0);
    tick(); chk_beat("s2", 1'b1, 2'd2, 2'b11, 1'b1);
    tick(); chk_beat("s3", 1'b0, 2'd0, 2'b11, 1'b0);

    // stalled beat 1 with write to y1
    bus.scan_start = 1'b1; tick();
    bus.scan_start = 1'b0;
    tick(); chk_beat("st1", 1'b1, 2'd1, 2'b10, 1'b0);
    bus.scan_ready = 1'b0; bus.we = 1'b1; bus.sel = 2'd1; bus.idata = 2'b00; tick();
    bus.we = 1'b0;
    chk("st_y1", 32'(bus.y1), 0);
    chk_beat("st_h0", 1'b1, 2'd1, 2'b10, 1'b0);
    tick(); chk_beat("st_h1", 1'b1, 2'd1, 2'b10, 1'b0);
    tick(); chk_beat("st_h2", 1'b1, 2'd1, 2'b10, 1'b0);
    bus.scan_ready = 1'b1; tick();
    chk_beat("st2", 1'b1, 2'd2, 2'b11, 1'b1);
    tick(); chk_beat("st3", 1'b0, 2'd0, 2'b11, 1'b0);
    chk("st_y1_after", 32'(bus.y1), 0);

    // start with same-edge write to y0 (bypass), then ignored restart
    bus.scan_start = 1'b1; bus.we = 1'b1; bus.sel = 2'd0; bus.idata = 2'b11; tick();
    bus.we = 1'b0;
    chk_beat("bp0", 1'b1, 2'd0, 2'b11, 1'b0);
    chk("bp_y0", 32'(bus.y0), 3);
    tick(); chk_beat("bp1", 1'b1, 2'd1, 2'b00, 1'b0);
    tick(); chk_beat("bp2", 1'b1, 2'd2, 2'b11, 1'b1);
    bus.scan_start = 1'b0;
    tick(); chk_beat("bp3", 1'b0, 2'd0, 2'b11, 1'b0);

    // async reset between beats 1 and 2
    bus.scan_start = 1'b1; tick();
    bus.scan_start = 1'b0;
    tick(); chk_beat("ar1", 1'b1, 2'd1, 2'b00, 1'b0);
    bus.scan_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_beat("ar_rst", 1'b0, 2'd0, 2'd0, 1'b0);
    chk("ar_y0", 32'(bus.y0), 0);
    chk("ar_y2", 32'(bus.y2), 0);
    tick();
    rst = 1'b0;
    bus.scan_start = 1'b1; bus.scan_ready = 1'b1; tick();
    bus.scan_start = 1'b0;
    chk_beat("ar_s0", 1'b1, 2'd0, 2'd0, 1'b0);
    tick(); chk_beat("ar_s1", 1'b1, 2'd1, 2'd0, 1'b0);
    tick(); chk_beat("ar_s2", 1'b1, 2'd2, 2'd0, 1'b1);
    tick(); chk_beat("ar_s3", 1'b0, 2'd0, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
